// File: rtl/spi_cmd_master.sv
// SPI command master: serializes 11-bit header+payload frames on mosi.
// For read-data commands it also shifts an 8-bit response in from miso.
// Mode-0 style link: sclk idles low, the slave samples on rise, and mosi
// changes on fall.
module spi_cmd_master #(
    parameter int HALF_DIV      = 2,
    parameter int RD_TURNAROUND = 1,
    parameter int SS_GAP        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int CW = 16;

    // Terminal counts, pre-sized to the counter width
    localparam logic [CW-1:0] DIV_LAST  = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(21);
    localparam logic [CW-1:0] RX_LAST   = CW'(15);
    localparam logic [CW-1:0] TURN_LAST = CW'((RD_TURNAROUND > 0) ? (2 * RD_TURNAROUND - 1) : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'((SS_GAP > 0) ? (SS_GAP - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX,
        TURN,
        RX,
        HOLD,
        GAP
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   div_cnt_reg;   // clk cycles within the current half-period
    logic [CW-1:0]   half_cnt_reg;  // completed half-periods within the phase
    logic [9:0]      shift_reg;     // remaining frame bits; bit 10 goes out at accept
    logic [7:0]      rx_shift_reg;
    logic            is_rd_reg;

    logic div_last;
    logic gap_last;

    assign div_last = (div_cnt_reg == DIV_LAST);
    assign gap_last = (div_cnt_reg == GAP_LAST);

    // Frame sequencer: every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            shift_reg    <= '0;
            rx_shift_reg <= '0;
            is_rd_reg    <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            ss_n         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Frame is cmd[1], cmd[1], cmd[0], data[7:0]
                        state_reg   <= SETUP;
                        shift_reg   <= {cmd, cmd_data};
                        mosi        <= cmd[1];
                        is_rd_reg   <= (cmd == 2'b11);
                        div_cnt_reg <= '0;
                        ss_n        <= 1'b0;
                        sclk        <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                SETUP: begin
                    if (div_last) begin
                        div_cnt_reg  <= '0;
                        half_cnt_reg <= '0;
                        sclk         <= 1'b1;
                        state_reg    <= TX;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                TX: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (half_cnt_reg == TX_LAST) begin
                            // 11 full periods done; sclk is already low
                            half_cnt_reg <= '0;
                            if (!is_rd_reg) begin
                                state_reg <= HOLD;
                            end else if (RD_TURNAROUND > 0) begin
                                state_reg <= TURN;
                                sclk      <= 1'b1;
                            end else begin
                                // First RX rise: capture miso as sclk goes high
                                state_reg    <= RX;
                                sclk         <= 1'b1;
                                rx_shift_reg <= {rx_shift_reg[6:0], miso};
                            end
                        end else begin
                            half_cnt_reg <= half_cnt_reg + 1'b1;
                            sclk         <= ~sclk;
                            if (sclk) begin
                                // Falling edge: present the next frame bit
                                mosi      <= shift_reg[9];
                                shift_reg <= {shift_reg[8:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                TURN: begin
                    mosi <= 1'b0;
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (half_cnt_reg == TURN_LAST) begin
                            half_cnt_reg <= '0;
                            state_reg    <= RX;
                            sclk         <= 1'b1;
                            rx_shift_reg <= {rx_shift_reg[6:0], miso};
                        end else begin
                            half_cnt_reg <= half_cnt_reg + 1'b1;
                            sclk         <= ~sclk;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                RX: begin
                    mosi <= 1'b0;
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (half_cnt_reg == RX_LAST) begin
                            half_cnt_reg <= '0;
                            sclk         <= 1'b0;
                            state_reg    <= HOLD;
                        end else begin
                            half_cnt_reg <= half_cnt_reg + 1'b1;
                            sclk         <= ~sclk;
                            if (!sclk) begin
                                // Rising edge: sample the response bit
                                rx_shift_reg <= {rx_shift_reg[6:0], miso};
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                HOLD: begin
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        ss_n        <= 1'b1;
                        if (is_rd_reg) begin
                            rx_data  <= rx_shift_reg;
                            rx_valid <= 1'b1;
                        end
                        if (SS_GAP > 0) begin
                            state_reg <= GAP;
                        end else begin
                            state_reg <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_last) begin
                        div_cnt_reg <= '0;
                        state_reg   <= IDLE;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    ss_n      <= 1'b1;
                    sclk      <= 1'b0;
                    mosi      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: DUT 0 uses HALF_DIV=2 and RD_TURNAROUND=1.
// DUT 1 uses HALF_DIV=1 and RD_TURNAROUND=0. Each DUT has its own bus
// monitor and miso slave model.
module tb_spi_cmd_master;

    logic clk;
    logic rst_n;

    logic       cmd_valid_w [2];
    logic       cmd_ready_w [2];
    logic [1:0] cmd_w       [2];
    logic [7:0] cmd_data_w  [2];
    logic [7:0] rx_data_w   [2];
    logic       rx_valid_w  [2];
    logic       busy_w      [2];
    logic       ss_n_w      [2];
    logic       sclk_w      [2];
    logic       mosi_w      [2];
    logic       miso_w      [2];
    logic [7:0] slave_resp  [2];

    int         mon_low      [2];
    int         mon_rises    [2];
    int         mon_done     [2];
    int         mon_rxv      [2];
    int         mon_extra    [2];
    int         mon_gap      [2];
    int         mon_outside  [2];
    int         mon_rdy_bad  [2];
    int         mon_busy_bad [2];
    int         mon_rxv_pos  [2];
    logic [10:0] mon_bits    [2];
    logic [7:0]  mon_rx_at   [2];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int START = (gi == 0) ? 12 : 11;

        spi_cmd_master #(
            .HALF_DIV      ((gi == 0) ? 2 : 1),
            .RD_TURNAROUND ((gi == 0) ? 1 : 0),
            .SS_GAP        (2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid_w[gi]),
            .cmd_ready (cmd_ready_w[gi]),
            .cmd       (cmd_w[gi]),
            .cmd_data  (cmd_data_w[gi]),
            .rx_data   (rx_data_w[gi]),
            .rx_valid  (rx_valid_w[gi]),
            .busy      (busy_w[gi]),
            .ss_n      (ss_n_w[gi]),
            .sclk      (sclk_w[gi]),
            .mosi      (mosi_w[gi]),
            .miso      (miso_w[gi])
        );

        logic        prev_ss   = 1'b1;
        logic        prev_sclk = 1'b0;
        int          low_cnt   = 0;
        int          rises     = 0;
        int          done      = 0;
        int          rxv       = 0;
        int          extra     = 0;
        int          hi_run    = 0;
        int          last_gap  = 0;
        int          outside   = 0;
        int          rdy_bad   = 0;
        int          busy_bad  = 0;
        int          rxv_pos   = 0;
        logic [10:0] bits      = '0;
        logic [7:0]  rx_at     = '0;
        int          falls     = 0;
        logic        miso_r    = 1'b0;
        logic [7:0]  resp;

        assign resp       = slave_resp[gi];
        assign miso_w[gi] = miso_r;

        // Bus monitor sampled on the falling clk edge
        always @(negedge clk) begin
            prev_ss   <= ss_n_w[gi];
            prev_sclk <= sclk_w[gi];
            if (prev_ss && !ss_n_w[gi]) begin
                low_cnt  <= 1;
                rises    <= 0;
                bits     <= '0;
                extra    <= 0;
                last_gap <= hi_run;
                hi_run   <= 0;
            end else if (!ss_n_w[gi]) begin
                low_cnt <= low_cnt + 1;
            end
            if (ss_n_w[gi]) hi_run <= hi_run + 1;
            if (!prev_ss && ss_n_w[gi]) done <= done + 1;
            if (sclk_w[gi] && !prev_sclk) begin
                rises <= rises + 1;
                if (rises < 11) bits <= {bits[9:0], mosi_w[gi]};
                else if (mosi_w[gi]) extra <= extra + 1;
            end
            if (sclk_w[gi] && ss_n_w[gi]) outside <= outside + 1;
            if (cmd_ready_w[gi] && !ss_n_w[gi]) rdy_bad <= rdy_bad + 1;
            if (busy_w[gi] == cmd_ready_w[gi]) busy_bad <= busy_bad + 1;
            if (rx_valid_w[gi]) begin
                rxv   <= rxv + 1;
                rx_at <= rx_data_w[gi];
                if (!(ss_n_w[gi] && !prev_ss)) rxv_pos <= rxv_pos + 1;
            end
        end

        // Slave response: next bit is driven after each sclk fall from the START-th on
        always @(negedge clk) begin
            if (prev_ss && !ss_n_w[gi]) begin
                falls  <= 0;
                miso_r <= 1'b0;
            end else if (prev_sclk && !sclk_w[gi]) begin
                falls <= falls + 1;
                if ((falls + 1 >= START) && (falls + 1 < START + 8))
                    miso_r <= resp[3'(START + 6 - falls)];
                else
                    miso_r <= 1'b0;
            end
        end

        assign mon_low[gi]      = low_cnt;
        assign mon_rises[gi]    = rises;
        assign mon_done[gi]     = done;
        assign mon_rxv[gi]      = rxv;
        assign mon_extra[gi]    = extra;
        assign mon_gap[gi]      = last_gap;
        assign mon_outside[gi]  = outside;
        assign mon_rdy_bad[gi]  = rdy_bad;
        assign mon_busy_bad[gi] = busy_bad;
        assign mon_rxv_pos[gi]  = rxv_pos;
        assign mon_bits[gi]     = bits;
        assign mon_rx_at[gi]    = rx_at;
    end

    typedef struct {
        int          dut;
        logic [1:0]  c;
        logic [7:0]  d;
        logic [7:0]  resp;
        logic [10:0] bits;
        int          rises;
        int          low;
        int          rxv;
        logic [7:0]  rxd;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [1:0] c, input logic [7:0] v);
        int n = 0;
        while (!cmd_ready_w[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", int'(n < 2000), 1);
        cmd_w[d]       = c;
        cmd_data_w[d]  = v;
        cmd_valid_w[d] = 1'b1;
        @(negedge clk);
        cmd_valid_w[d] = 1'b0;
        cmd_w[d]       = ~c;
        cmd_data_w[d]  = ~v;
    endtask

    task automatic wait_frame(input int d, input int base);
        int n = 0;
        while (mon_done[d] == base && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", int'(n < 2000), 1);
        @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v);
        int base_done = mon_done[v.dut];
        int base_rxv  = mon_rxv[v.dut];
        slave_resp[v.dut] = v.resp;
        send(v.dut, v.c, v.d);
        wait_frame(v.dut, base_done);
        check("frame_bits", int'(mon_bits[v.dut]), int'(v.bits));
        check("sclk_rises", mon_rises[v.dut], v.rises);
        check("ss_low_cycles", mon_low[v.dut], v.low);
        check("mosi_after_frame", mon_extra[v.dut], 0);
        check("rx_valid_pulses", mon_rxv[v.dut] - base_rxv, v.rxv);
        check("rx_data_hold", int'(rx_data_w[v.dut]), int'(v.rxd));
        if (v.rxv != 0) check("rx_data_at_pulse", int'(mon_rx_at[v.dut]), int'(v.rxd));
        $display("txn dut=%0d cmd=%0d data=%02h bits=%03h rises=%0d low=%0d rx=%02h",
                 v.dut, v.c, v.d, mon_bits[v.dut], mon_rises[v.dut], mon_low[v.dut],
                 rx_data_w[v.dut]);
    endtask

    initial begin
        int base_done;
        int base_rxv;
        int n;

        vt[0] = '{0, 2'b00, 8'hA5, 8'h00, 11'b000_10100101, 11, 48, 0, 8'h00};
        vt[1] = '{0, 2'b01, 8'h3C, 8'h00, 11'b001_00111100, 11, 48, 0, 8'h00};
        vt[2] = '{0, 2'b10, 8'hFF, 8'h00, 11'b110_11111111, 11, 48, 0, 8'h00};
        vt[3] = '{0, 2'b11, 8'h00, 8'hC3, 11'b111_00000000, 20, 84, 1, 8'hC3};
        vt[4] = '{0, 2'b11, 8'h5A, 8'h96, 11'b111_01011010, 20, 84, 1, 8'h96};
        vt[5] = '{0, 2'b10, 8'h00, 8'h55, 11'b110_00000000, 11, 48, 0, 8'h96};
        vt[6] = '{1, 2'b11, 8'h81, 8'h6B, 11'b111_10000001, 19, 40, 1, 8'h6B};

        for (int i = 0; i < 2; i++) begin
            cmd_valid_w[i] = 1'b0;
            cmd_w[i]       = 2'b00;
            cmd_data_w[i]  = 8'h00;
            slave_resp[i]  = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            check("rst_ss_n", int'(ss_n_w[i]), 1);
            check("rst_sclk", int'(sclk_w[i]), 0);
            check("rst_mosi", int'(mosi_w[i]), 0);
            check("rst_cmd_ready", int'(cmd_ready_w[i]), 1);
            check("rst_busy", int'(busy_w[i]), 0);
            check("rst_rx_valid", int'(rx_valid_w[i]), 0);
            check("rst_rx_data", int'(rx_data_w[i]), 0);
        end
        $display("txn reset defaults checked");

        // Asynchronous reset in the middle of a write-data frame
        base_rxv = mon_rxv[0];
        send(0, 2'b01, 8'hFF);
        repeat (20) @(negedge clk);
        check("pre_rst_mosi", int'(mosi_w[0]), 1);
        check("pre_rst_ss_n", int'(ss_n_w[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ss_n", int'(ss_n_w[0]), 1);
        check("midrst_sclk", int'(sclk_w[0]), 0);
        check("midrst_mosi", int'(mosi_w[0]), 0);
        check("midrst_cmd_ready", int'(cmd_ready_w[0]), 1);
        check("midrst_busy", int'(busy_w[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_rx_valid", mon_rxv[0] - base_rxv, 0);
        $display("txn mid-frame reset on dut=0");

        for (int i = 0; i < 7; i++) apply_vec(vt[i]);

        // Back-to-back: valid stays high across two commands
        base_done = mon_done[0];
        n = 0;
        while (!cmd_ready_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cmd_w[0]       = 2'b01;
        cmd_data_w[0]  = 8'hA5;
        cmd_valid_w[0] = 1'b1;
        @(negedge clk);
        cmd_w[0]      = 2'b00;
        cmd_data_w[0] = 8'hC3;
        n = 0;
        while (!cmd_ready_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_timeout", int'(n < 2000), 1);
        @(negedge clk);
        cmd_valid_w[0] = 1'b0;
        check("b2b_first_done", mon_done[0] - base_done, 1);
        wait_frame(0, base_done + 1);
        check("b2b_frames", mon_done[0] - base_done, 2);
        check("b2b_gap", mon_gap[0], 3);
        check("b2b_bits", int'(mon_bits[0]), int'(11'b000_11000011));
        check("b2b_low", mon_low[0], 48);
        $display("txn back-to-back dut=0 gap=%0d bits=%03h", mon_gap[0], mon_bits[0]);

        for (int i = 0; i < 2; i++) begin
            check("sclk_outside_frame", mon_outside[i], 0);
            check("ready_during_frame", mon_rdy_bad[i], 0);
            check("busy_vs_ready", mon_busy_bad[i], 0);
            check("rx_valid_position", mon_rxv_pos[i], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI master that issues framed commands to the SPI slave command decoder: write-address, write-data, read-address and read-data.
- Accepts one command per valid/ready handshake and serializes an 11-bit header+payload frame on mosi while generating ss_n and sclk.
- For read-data commands, it also shifts in the 8-bit response on miso and presents it on rx_data with a one-cycle rx_valid strobe.

Parameters:
- HALF_DIV, 2, clk cycles per sclk half-period; minimum 1; sclk period = 2*HALF_DIV clk cycles.
- RD_TURNAROUND, 1, full sclk periods between the last transmitted bit and the first sampled miso bit on read-data; miso is ignored during these periods.
- SS_GAP, 2, minimum clk cycles with ss_n high between consecutive frames.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  in  8  address or data payload.
- rx_data  out  8  last read-data response.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from command accept until IDLE is re-entered.
- ss_n  out  1  slave select, active-low.
- sclk  out  1  serial clock, idle low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (async, takes effect immediately, including mid-frame): state IDLE, ss_n=1, sclk=0, mosi=0, cmd_ready=1, busy=0, rx_valid=0, rx_data=0. A partial frame is abandoned with no rx_valid pulse.
- Frame format, MSB first, 11 bits: cmd[1], cmd[1], cmd[0], cmd_data[7:6..0].
  - Write headers are 000 and 001; read headers are 110 and 111.
- Accept: cmd_valid & cmd_ready at a rising clk edge. cmd and cmd_data are captured into a shift register; later changes on the inputs are ignored.
- cmd_ready = 1 only in IDLE. busy = !cmd_ready.
- States:
  - IDLE:
    - ss_n=1, sclk=0.
    - On accept, go to SETUP.
  - SETUP:
    - ss_n=0, sclk=0, mosi = frame bit 10.
    - Lasts HALF_DIV cycles, then go to TX.
  - TX:
    - sclk toggles every HALF_DIV cycles, starting high.
    - Slave samples on sclk rise.
    - On each sclk fall the master shifts mosi to the next bit.
    - After 11 complete sclk periods (ending on a fall): cmd==11 goes to TURN; otherwise goes to HOLD.
  - TURN:
    - RD_TURNAROUND full sclk periods, miso not sampled.
    - mosi=0.
    - If RD_TURNAROUND=0, skip directly to RX.
  - RX:
    - 8 sclk periods.
    - miso is sampled on each sclk rise into rx_shift MSB first.
    - mosi=0.
    - Then go to HOLD.
  - HOLD:
    - sclk=0, ss_n still 0, lasts HALF_DIV cycles.
    - On exit ss_n=1. For read-data, rx_data <= rx_shift and rx_valid=1 for exactly that one cycle.
    - Go to GAP.
  - GAP:
    - ss_n=1, lasts SS_GAP cycles (skip if 0), then go to IDLE.
- sclk is low whenever ss_n is high; no sclk edges occur outside TX/TURN/RX.
- Frame length with ss_n low:
  - Non-read-data: 2*HALF_DIV + 22*HALF_DIV clk cycles.
  - Read-data: adds 2*HALF_DIV*(RD_TURNAROUND+8) clk cycles.
- rx_data holds its value until the next read-data completion; read-addr and write commands never update it.
- cmd_valid asserted during a frame is held off (cmd_ready=0) and accepted on the first IDLE cycle. Back-to-back commands are separated by exactly SS_GAP+1 cycles of ss_n high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset defaults: assert rst_n=0 mid-TX of a write-data frame -> ss_n=1, sclk=0, mosi=0, cmd_ready=1 in the same cycle; no rx_valid; next command runs a full frame.
- Write-addr, HALF_DIV=2: cmd=00, cmd_data=8'hA5 -> ss_n falls one cycle after accept and stays low 48 cycles; exactly 11 sclk rises; mosi sampled at the rises = 0,0,0,1,0,1,0,0,1,0,1.
- Write-data / read-addr: cmd=01, data=8'h3C -> header 001 then 00111100. cmd=10, data=8'hFF -> header 110 then 11111111; no rx_valid and rx_data unchanged for both.
- Read-data, RD_TURNAROUND=1: cmd=11, data=8'h00, slave model drives 8'hC3 on miso after the 12th sclk period -> 20 sclk rises total; ss_n low 84 cycles; rx_valid single pulse with rx_data=8'hC3 on the ss_n rising cycle.
- Back-to-back: cmd_valid held high with two commands -> second accepted on the first IDLE cycle; ss_n high for exactly 3 cycles (SS_GAP=2) between frames; cmd_ready=0 throughout each frame.
- HALF_DIV=1 and RD_TURNAROUND=0: read-data -> sclk toggles every clk cycle; miso sampled starting at the 12th rise; rx_data correct.
